core_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32I-subset datapath. Decodes the current instruction and drives every datapath control input. Sequences fetch, execute and data-memory phases with ready-based handshakes, and gates architectural commits (register write, PC update) so the datapath tolerates variable-latency instruction and data memories. Sits beside the datapath inside the core top level, between the datapath and the memory ports.

---
 rtl/core_pkg.sv | 61 ++++++
 rtl/ctrl_decode.sv | 88 ++++++++
 rtl/core_sequencer.sv | 114 +++++++++++
 tb/tb_core_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I-subset core: sequencer states, opcodes,
// and the control encodings consumed by the datapath muxes and the ALU.
package core_pkg;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_TRAP  = 3'd4
    } state_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;

    typedef struct packed {
        logic       alu_src;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
        logic [1:0] result_src;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       pc_write;
        logic       mem_write;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: produces the EXEC-phase control bundle,
// plus flags telling the sequencer whether a data-memory phase follows or the opcode is illegal.
module ctrl_decode
    import core_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        zero,
    output ctrl_t       ctrl,
    output logic        is_mem,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        ctrl    = CTRL_NONE;
        is_mem  = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_IALU: begin
                ctrl.alu_src   = (opcode == OP_IALU);
                ctrl.imm_src   = IMM_I;
                ctrl.reg_write = 1'b1;
                ctrl.pc_write  = 1'b1;
                case (funct3)
                    // addi ignores bit 30 since it is part of the immediate
                    F3_ADD:  ctrl.alu_control = (opcode == OP_RTYPE && instr[30]) ? ALU_SUB : ALU_ADD;
                    F3_SLT:  ctrl.alu_control = ALU_SLT;
                    F3_OR:   ctrl.alu_control = ALU_OR;
                    F3_AND:  ctrl.alu_control = ALU_AND;
                    default: begin
                        ctrl    = CTRL_NONE;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    ctrl.alu_control = ALU_SUB;
                    ctrl.imm_src     = IMM_B;
                    ctrl.pc_src      = zero ? PC_TARGET : PC_PLUS4;
                    ctrl.pc_write    = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_JAL: begin
                ctrl.imm_src    = IMM_J;
                ctrl.pc_src     = PC_TARGET;
                ctrl.result_src = RES_PC4;
                ctrl.reg_write  = 1'b1;
                ctrl.pc_write   = 1'b1;
            end
            OP_JALR: begin
                if (funct3 == F3_JALR) begin
                    ctrl.alu_src     = 1'b1;
                    ctrl.imm_src     = IMM_I;
                    ctrl.alu_control = ALU_ADD;
                    ctrl.pc_src      = PC_ALU;
                    ctrl.result_src  = RES_PC4;
                    ctrl.reg_write   = 1'b1;
                    ctrl.pc_write    = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_LOAD, OP_STORE: begin
                if (funct3 == F3_WORD) begin
                    ctrl.alu_src     = 1'b1;
                    ctrl.imm_src     = (opcode == OP_STORE) ? IMM_S : IMM_I;
                    ctrl.alu_control = ALU_ADD;
                    ctrl.mem_write   = (opcode == OP_STORE);
                    is_mem           = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I-subset core: sequences fetch, execute and
// data-memory phases on ready handshakes and gates register/PC commits.
module core_sequencer
    import core_pkg::*;
#(
    parameter int width = 32
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      Instr,
    input  logic             Zero,
    input  logic             IReady,
    input  logic             DReady,
    output logic             IReq,
    output logic             MemReq,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             PCWrite,
    output logic             ALUSrc,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUControl,
    output logic             Halt,
    output logic [width-1:0] InstRet
);

    state_e           state_q, state_d;
    logic [width-1:0] inst_ret_q, inst_ret_d;

    ctrl_t dec_ctrl;
    logic  dec_is_mem;
    logic  dec_illegal;

    ctrl_t ctrl_out;
    logic  ireq;
    logic  mem_req;
    logic  halt;

    ctrl_decode u_decode (
        .instr   (Instr),
        .zero    (Zero),
        .ctrl    (dec_ctrl),
        .is_mem  (dec_is_mem),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d  = state_q;
        ctrl_out = CTRL_NONE;
        ireq     = 1'b0;
        mem_req  = 1'b0;
        halt     = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                ireq = 1'b1;
                if (IReady) state_d = ST_FETCH == ST_FETCH ? ST_EXEC : ST_FETCH;
            end
            ST_EXEC: begin
                ctrl_out           = dec_ctrl;
                ctrl_out.mem_write = 1'b0;
                if (dec_illegal)     state_d = ST_TRAP;
                else if (dec_is_mem) state_d = ST_MEM;
                else                 state_d = ST_FETCH;
            end
            ST_MEM: begin
                // Instr is still stable here, so the address path keeps its EXEC settings
                ctrl_out.alu_src     = dec_ctrl.alu_src;
                ctrl_out.imm_src     = dec_ctrl.imm_src;
                ctrl_out.alu_control = dec_ctrl.alu_control;
                ctrl_out.mem_write   = dec_ctrl.mem_write;
                mem_req              = 1'b1;
                if (DReady) begin
                    ctrl_out.pc_write = 1'b1;
                    if (!dec_ctrl.mem_write) begin
                        ctrl_out.reg_write  = 1'b1;
                        ctrl_out.result_src = RES_MEM;
                    end
                    state_d = ST_FETCH;
                end
            end
            ST_TRAP: halt = 1'b1;
            default: state_d = ST_BOOT;
        endcase
    end

    assign inst_ret_d = inst_ret_q + {{(width-1){1'b0}}, ctrl_out.pc_write};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_BOOT;
            inst_ret_q <= '0;
        end else begin
            state_q    <= state_d;
            inst_ret_q <= inst_ret_d;
        end
    end

    assign IReq       = ireq;
    assign MemReq     = mem_req;
    assign MemWrite   = ctrl_out.mem_write;
    assign RegWrite   = ctrl_out.reg_write;
    assign PCWrite    = ctrl_out.pc_write;
    assign ALUSrc     = ctrl_out.alu_src;
    assign ImmSrc     = ctrl_out.imm_src;
    assign ResultSrc  = ctrl_out.result_src;
    assign PCSrc      = ctrl_out.pc_src;
    assign ALUControl = ctrl_out.alu_control;
    assign Halt       = halt;
    assign InstRet    = inst_ret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: expected commits are queued when an
// instruction is presented and compared when the DUT pulses PCWrite.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] Instr;
    logic        Zero;
    logic        IReady;
    logic        DReady;
    logic        IReq;
    logic        MemReq;
    logic        MemWrite;
    logic        RegWrite;
    logic        PCWrite;
    logic        ALUSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  ResultSrc;
    logic [1:0]  PCSrc;
    logic [2:0]  ALUControl;
    logic        Halt;
    logic [31:0] InstRet;

    typedef struct packed {
        logic [7:0] id;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] pc_src;
        logic       alu_src;
        logic [2:0] alu_control;
        logic       mem_write;
        logic       check_imm;
        logic [1:0] imm_src;
    } commit_t;

    commit_t     expQ[$];
    int          errors = 0;
    int          checks = 0;
    int          memReqCount = 0;
    logic [31:0] retiredModel = 32'd0;

    localparam logic [31:0] I_ADD    = 32'h002081B3;
    localparam logic [31:0] I_SUB    = 32'h402081B3;
    localparam logic [31:0] I_AND    = 32'h0020F233;
    localparam logic [31:0] I_OR     = 32'h0020E233;
    localparam logic [31:0] I_SLT    = 32'h0020A233;
    localparam logic [31:0] I_ADDI   = 32'h00508293;
    localparam logic [31:0] I_ADDI30 = 32'h40008293;
    localparam logic [31:0] I_LW     = 32'h0080A283;
    localparam logic [31:0] I_SW     = 32'h0050A423;
    localparam logic [31:0] I_BEQ    = 32'h00208463;
    localparam logic [31:0] I_JAL    = 32'h010000EF;
    localparam logic [31:0] I_JALR   = 32'h004100E7;
    localparam logic [31:0] I_ILLEG  = 32'h00000000;

    core_sequencer #(.width(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Instr      (Instr),
        .Zero       (Zero),
        .IReady     (IReady),
        .DReady     (DReady),
        .IReq       (IReq),
        .MemReq     (MemReq),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .PCWrite    (PCWrite),
        .ALUSrc     (ALUSrc),
        .ImmSrc     (ImmSrc),
        .ResultSrc  (ResultSrc),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .Halt       (Halt),
        .InstRet    (InstRet)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic commit_t mkCommit(input logic [7:0] id, input logic rw, input logic [1:0] rs,
                                         input logic [1:0] ps, input logic as, input logic [2:0] ac,
                                         input logic mw, input logic ci, input logic [1:0] is);
        commit_t c;
        c.id          = id;
        c.reg_write   = rw;
        c.result_src  = rs;
        c.pc_src      = ps;
        c.alu_src     = as;
        c.alu_control = ac;
        c.mem_write   = mw;
        c.check_imm   = ci;
        c.imm_src     = is;
        return c;
    endfunction

    // Sample at the falling edge, scoring any commit against the queue, then
    // return 1 time unit after the next rising edge so inputs can be driven.
    task automatic stepCycle();
        commit_t e;
        @(negedge clk);
        if (MemReq === 1'b1) memReqCount++;
        if (PCWrite === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_pcwrite", 32'(PCWrite), 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput($sformatf("c%0d_regwrite", e.id), 32'(RegWrite), 32'(e.reg_write));
                checkOutput($sformatf("c%0d_resultsrc", e.id), 32'(ResultSrc), 32'(e.result_src));
                checkOutput($sformatf("c%0d_pcsrc", e.id), 32'(PCSrc), 32'(e.pc_src));
                checkOutput($sformatf("c%0d_alusrc", e.id), 32'(ALUSrc), 32'(e.alu_src));
                checkOutput($sformatf("c%0d_alucontrol", e.id), 32'(ALUControl), 32'(e.alu_control));
                checkOutput($sformatf("c%0d_memwrite", e.id), 32'(MemWrite), 32'(e.mem_write));
                if (e.check_imm)
                    checkOutput($sformatf("c%0d_immsrc", e.id), 32'(ImmSrc), 32'(e.imm_src));
                checkOutput($sformatf("c%0d_instret", e.id), InstRet, retiredModel);
                retiredModel = retiredModel + 32'd1;
            end
        end else if (RegWrite === 1'b1) begin
            checkOutput("regwrite_without_pcwrite", 32'(RegWrite), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset_n      = 1'b0;
        IReady       = 1'b0;
        DReady       = 1'b0;
        retiredModel = 32'd0;
        stepCycle();
        checkOutput("reset_ireq", 32'(IReq), 32'd0);
        checkOutput("reset_pcwrite", 32'(PCWrite), 32'd0);
        checkOutput("reset_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("reset_memreq", 32'(MemReq), 32'd0);
        checkOutput("reset_halt", 32'(Halt), 32'd0);
        checkOutput("reset_instret", InstRet, 32'd0);
        stepCycle();
        reset_n = 1'b1;
        checkOutput("boot_ireq", 32'(IReq), 32'd0);
        stepCycle();
    endtask

    // Runs one instruction starting from FETCH; `noise` raises the ready
    // inputs in phases where they must be ignored.
    task automatic applyStimulus(input logic [7:0] id, input logic [31:0] instr, input logic zero,
                                 input int iwait, input int dwait, input logic isMem,
                                 input logic isTrap, input logic noise, input commit_t exp);
        int memStart;
        checkOutput($sformatf("i%0d_fetch_ireq", id), 32'(IReq), 32'd1);
        Instr  = instr;
        Zero   = zero;
        DReady = noise;
        IReady = 1'b0;
        repeat (iwait) stepCycle();
        IReady = 1'b1;
        if (!isTrap) expQ.push_back(exp);
        stepCycle();
        IReady = 1'b0;
        checkOutput($sformatf("i%0d_exec_ireq", id), 32'(IReq), 32'd0);
        if (isMem) begin
            stepCycle();
            memStart = memReqCount;
            DReady   = 1'b0;
            IReady   = noise;
            repeat (dwait) stepCycle();
            DReady = 1'b1;
            stepCycle();
            DReady = 1'b0;
            IReady = 1'b0;
            checkOutput($sformatf("i%0d_memreq_cycles", id), 32'(memReqCount - memStart), 32'(dwait + 1));
        end else begin
            stepCycle();
        end
        DReady = 1'b0;
        if (!isTrap) checkOutput($sformatf("i%0d_refetch_ireq", id), 32'(IReq), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        Instr   = 32'd0;
        Zero    = 1'b0;
        IReady  = 1'b0;
        DReady  = 1'b0;
        $display("[TB] starting core_sequencer bench");

        doReset();
        applyStimulus(8'd1, I_ADD, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0,
                      mkCommit(8'd1, 1'b1, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00));
        checkOutput("instret_after_add", InstRet, 32'd1);

        applyStimulus(8'd2, I_SUB, 1'b1, 1, 0, 1'b0, 1'b0, 1'b1,
                      mkCommit(8'd2, 1'b1, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0, 2'b00));
        applyStimulus(8'd3, I_AND, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0,
                      mkCommit(8'd3, 1'b1, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0, 2'b00));
        applyStimulus(8'd4, I_OR, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1,
                      mkCommit(8'd4, 1'b1, 2'b00, 2'b00, 1'b0, 3'b011, 1'b0, 1'b0, 2'b00));
        applyStimulus(8'd5, I_SLT, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0,
                      mkCommit(8'd5, 1'b1, 2'b00, 2'b00, 1'b0, 3'b101, 1'b0, 1'b0, 2'b00));
        applyStimulus(8'd6, I_ADDI, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0,
                      mkCommit(8'd6, 1'b1, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 1'b1, 2'b00));
        applyStimulus(8'd7, I_ADDI30, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0,
                      mkCommit(8'd7, 1'b1, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 1'b1, 2'b00));
        applyStimulus(8'd8, I_LW, 1'b0, 0, 3, 1'b1, 1'b0, 1'b1,
                      mkCommit(8'd8, 1'b1, 2'b01, 2'b00, 1'b1, 3'b000, 1'b0, 1'b1, 2'b00));
        applyStimulus(8'd9, I_SW, 1'b0, 1, 0, 1'b1, 1'b0, 1'b1,
                      mkCommit(8'd9, 1'b0, 2'b00, 2'b00, 1'b1, 3'b000, 1'b1, 1'b1, 2'b01));
        applyStimulus(8'd10, I_BEQ, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0,
                      mkCommit(8'd10, 1'b0, 2'b00, 2'b01, 1'b0, 3'b001, 1'b0, 1'b1, 2'b10));
        applyStimulus(8'd11, I_BEQ, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0,
                      mkCommit(8'd11, 1'b0, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, 1'b1, 2'b10));
        applyStimulus(8'd12, I_JAL, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0,
                      mkCommit(8'd12, 1'b1, 2'b10, 2'b01, 1'b0, 3'b000, 1'b0, 1'b1, 2'b11));
        applyStimulus(8'd13, I_JALR, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0,
                      mkCommit(8'd13, 1'b1, 2'b10, 2'b10, 1'b1, 3'b000, 1'b0, 1'b1, 2'b00));
        checkOutput("instret_total", InstRet, 32'd13);

        // Illegal opcode parks the core in TRAP until reset
        applyStimulus(8'd14, I_ILLEG, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, '0);
        IReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("trap%0d_ireq", i), 32'(IReq), 32'd0);
            checkOutput($sformatf("trap%0d_halt", i), 32'(Halt), 32'd1);
            stepCycle();
        end
        IReady = 1'b0;
        checkOutput("trap_instret", InstRet, 32'd13);

        doReset();

        applyStimulus(8'd20, I_ADD, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0,
                      mkCommit(8'd20, 1'b1, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00));
        checkOutput("pre_abort_instret", InstRet, 32'd1);

        // Store stalled in MEM, then aborted by an asynchronous reset pulse
        Instr  = I_SW;
        IReady = 1'b1;
        stepCycle();
        IReady = 1'b0;
        DReady = 1'b0;
        stepCycle();
        checkOutput("abort_mem_memreq", 32'(MemReq), 32'd1);
        checkOutput("abort_mem_memwrite", 32'(MemWrite), 32'd1);
        stepCycle();
        checkOutput("abort_stall_memreq", 32'(MemReq), 32'd1);
        reset_n = 1'b0;
        #1;
        retiredModel = 32'd0;
        checkOutput("abort_pcwrite", 32'(PCWrite), 32'd0);
        checkOutput("abort_memreq", 32'(MemReq), 32'd0);
        checkOutput("abort_instret", InstRet, 32'd0);
        checkOutput("abort_ireq", 32'(IReq), 32'd0);
        DReady = 1'b1;
        stepCycle();
        stepCycle();
        DReady  = 1'b0;
        reset_n = 1'b1;
        checkOutput("abort_boot_ireq", 32'(IReq), 32'd0);
        checkOutput("abort_boot_instret", InstRet, 32'd0);
        stepCycle();
        checkOutput("abort_fetch_ireq", 32'(IReq), 32'd1);

        checkOutput("pending_commits", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
